// File: rtl/rr_sel_arbiter_pkg.sv
// Shared definitions for the round-robin select arbiter: FSM encoding and
// a one-hot helper sized for the widest select the package supports.
package rr_sel_arbiter_pkg;

    localparam int MAX_SIZE   = 8;
    localparam int MAX_INPUTS = 2 ** MAX_SIZE;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    // Callers truncate the result to their own INPUTS width.
    function automatic logic [MAX_INPUTS-1:0] onehot(input logic [MAX_SIZE-1:0] idx);
        return MAX_INPUTS'(1) << idx;
    endfunction

endpackage

// File: rtl/rr_sel_arbiter_prio.sv
// Rotating priority encoder: finds the first set req bit searching from
// ptr+1 upward (mod INPUTS), so input ptr is checked last.
module rr_prio_enc #(
    parameter int SIZE   = 2,
    parameter int INPUTS = 2 ** SIZE
) (
    input  logic [INPUTS-1:0] req,
    input  logic [SIZE-1:0]   ptr,
    output logic              any,
    output logic [SIZE-1:0]   idx
);

    logic [SIZE-1:0]   start;
    logic [INPUTS-1:0] rot;
    logic [SIZE-1:0]   low;

    assign start = ptr + SIZE'(1);
    // Rotate right via a doubled vector; the low half is the rotated request.
    assign rot   = INPUTS'({req, req} >> start);
    assign any   = |req;

    always_comb begin
        low = '0;
        for (int i = INPUTS - 1; i >= 0; i--) begin
            if (rot[i]) low = SIZE'(i);
        end
    end

    assign idx = low + start;

endmodule

// File: rtl/rr_sel_arbiter.sv
// Round-robin arbiter driving a Mux select: holds the grant until done,
// then rotates to the next requester with no idle bubble.
module rr_sel_arbiter
    import rr_sel_arbiter_pkg::*;
#(
    parameter int SIZE = 2,
    localparam int INPUTS = 2 ** SIZE
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [INPUTS-1:0] req,
    input  logic              done,
    output logic [SIZE-1:0]   sel,
    output logic [INPUTS-1:0] grant,
    output logic              valid
);

    state_e            state_q, state_d;
    logic [SIZE-1:0]   ptr_q, ptr_d;
    logic [SIZE-1:0]   sel_q, sel_d;
    logic [INPUTS-1:0] grant_q, grant_d;
    logic              valid_q, valid_d;

    logic [SIZE-1:0]   enc_ptr;
    logic              enc_any;
    logic [SIZE-1:0]   enc_idx;

    // On done the just-served input becomes the new pointer, so re-arbitrate
    // against sel directly rather than waiting for ptr_q to update.
    assign enc_ptr = (state_q == ST_BUSY) ? sel_q : ptr_q;

    rr_prio_enc #(.SIZE(SIZE), .INPUTS(INPUTS)) u_enc (
        .req (req),
        .ptr (enc_ptr),
        .any (enc_any),
        .idx (enc_idx)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        grant_d = grant_q;
        valid_d = valid_q;
        case (state_q)
            ST_IDLE: begin
                if (enc_any) begin
                    state_d = ST_BUSY;
                    sel_d   = enc_idx;
                    grant_d = INPUTS'(onehot(MAX_SIZE'(enc_idx)));
                    valid_d = 1'b1;
                end
            end
            ST_BUSY: begin
                if (done) begin
                    ptr_d = sel_q;
                    if (enc_any) begin
                        sel_d   = enc_idx;
                        grant_d = INPUTS'(onehot(MAX_SIZE'(enc_idx)));
                    end else begin
                        state_d = ST_IDLE;
                        grant_d = '0;
                        valid_d = 1'b0;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= SIZE'(INPUTS - 1);
            sel_q   <= '0;
            grant_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            grant_q <= grant_d;
            valid_q <= valid_d;
        end
    end

    assign sel   = sel_q;
    assign grant = grant_q;
    assign valid = valid_q;

endmodule
